// File: rtl/ascon_if_pkg.sv
// Shared definitions for the Ascon serial front-end.
//   state_t    : wrapper FSM states
//   calc_lb/ub : load / unload beat counts for a given lane width
//   calc_cw    : beat counter width
//   w_legal    : lane-width legality (power of two up to 32, divides all fields)
package ascon_if_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARMED,
    RUN,
    CAPTURE,
    UNLOAD
  } state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned calc_lb(input int unsigned k, input int unsigned nb,
                                          input int unsigned l, input int unsigned y,
                                          input int unsigned t, input int unsigned w);
    return max2(max2(max2(k, nb), max2(l, y)), t) / w;
  endfunction

  function automatic int unsigned calc_ub(input int unsigned y, input int unsigned t,
                                          input int unsigned w);
    return max2(y, t) / w;
  endfunction

  function automatic int unsigned calc_cw(input int unsigned lb, input int unsigned ub);
    return $clog2(max2(lb, ub) + 1);
  endfunction

  function automatic bit w_legal(input int unsigned w, input int unsigned k,
                                 input int unsigned nb, input int unsigned l,
                                 input int unsigned y, input int unsigned t);
    bit width_ok;
    width_ok = (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32);
    return width_ok && (k % w == 0) && (nb % w == 0) && (l % w == 0) &&
           (y % w == 0) && (t % w == 0);
  endfunction

endpackage

// File: rtl/ascon_lane_sr.sv
// Generic shift register with parallel load, shift-left-in and shift-right-out.
//   clk, rst  : clock, synchronous active-high reset (clears contents)
//   en        : global enable; no change when low
//   load      : parallel load of load_val (highest priority)
//   shl       : shift left by STEP, lane_in enters the low bits
//   shr       : shift right by STEP with zero fill
//   q         : low OUT_W bits of the register (full width by default)
module ascon_lane_sr #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned OUT_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shl,
  input  logic [STEP-1:0]  lane_in,
  input  logic             shr,
  output logic [OUT_W-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next contents; the shift form also covers WIDTH == STEP.
  always_comb begin
    q_d = q_q;
    if (en) begin
      if (load) begin
        q_d = load_val;
      end else if (shl) begin
        q_d = (q_q << STEP) | WIDTH'(lane_in);
      end else if (shr) begin
        q_d = q_q >> STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q[OUT_W-1:0];

endmodule

// File: rtl/ascon_stream_if.sv
// Serial valid/ready front-end for the Ascon core.
//   load_valid/load_ready + *_in lanes : W-bit input beats, MSB chunk first
//   start/decrypt                      : launch the core once all fields are loaded
//   out_valid/out_ready + *_out lanes  : W-bit result beats, LSB chunk first
//   auth_ok                            : tag check result (always 1 for encrypt)
//   busy                               : FSM not idle
//   core_*                             : direct connection to the Ascon core
module ascon_stream_if
  import ascon_if_pkg::*;
#(
  parameter int unsigned K  = 128,
  parameter int unsigned NB = 128,
  parameter int unsigned L  = 32,
  parameter int unsigned Y  = 32,
  parameter int unsigned T  = 128,
  parameter int unsigned W  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  key_in,
  input  logic [W-1:0]  nonce_in,
  input  logic [W-1:0]  ad_in,
  input  logic [W-1:0]  data_in,
  input  logic [W-1:0]  tag_in,
  input  logic          start,
  input  logic          decrypt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  data_out,
  output logic [W-1:0]  tag_out,
  output logic          auth_ok,
  output logic          busy,
  output logic [K-1:0]  core_key,
  output logic [NB-1:0] core_nonce,
  output logic [L-1:0]  core_ad,
  output logic [Y-1:0]  core_data,
  output logic          core_start,
  output logic          core_decrypt,
  input  logic [Y-1:0]  core_out,
  input  logic [T-1:0]  core_tag,
  input  logic          core_ready
);

  localparam int unsigned LB = calc_lb(K, NB, L, Y, T, W);
  localparam int unsigned UB = calc_ub(Y, T, W);
  localparam int unsigned CW = calc_cw(LB, UB);

  if (!w_legal(W, K, NB, L, Y, T)) begin : g_bad_w
    $error("ascon_stream_if: illegal lane width W=%0d", W);
  end

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           load_ready_q, load_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic           core_start_q, core_start_d;
  logic           core_decrypt_q, core_decrypt_d;
  logic           auth_ok_q, auth_ok_d;

  logic           load_acc;
  logic           unload_acc;
  logic           capture;
  logic           tag_match;
  logic [T-1:0]   texp;
  logic [Y-1:0]   out_load;

  assign load_acc   = load_valid & load_ready_q;
  assign unload_acc = out_valid_q & out_ready;
  assign capture    = (state_q == CAPTURE);
  assign tag_match  = (core_tag == texp);
  // Plaintext is suppressed when a decrypt fails authentication.
  assign out_load   = (core_decrypt_q && !tag_match) ? '0 : core_out;

  // Next state, beat counter and registered outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    core_start_d   = 1'b0;
    core_decrypt_d = core_decrypt_q;
    auth_ok_d      = auth_ok_q;
    unique case (state_q)
      IDLE, LOAD: begin
        if (load_acc) begin
          if (cnt_q == CW'(LB - 1)) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else begin
            state_d = LOAD;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      ARMED: begin
        if (start) begin
          state_d        = RUN;
          core_start_d   = 1'b1;
          core_decrypt_d = decrypt;
          auth_ok_d      = 1'b0;
        end
      end
      RUN: begin
        // core_ready may still be high from the previous run while the pulse is out.
        if (core_ready && !core_start_q) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d   = UNLOAD;
        auth_ok_d = core_decrypt_q ? tag_match : 1'b1;
      end
      UNLOAD: begin
        if (unload_acc) begin
          if (cnt_q == CW'(UB - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    load_ready_d = (state_d == IDLE) || (state_d == LOAD);
    out_valid_d  = (state_d == UNLOAD);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      load_ready_q   <= 1'b0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      core_start_q   <= 1'b0;
      core_decrypt_q <= 1'b0;
      auth_ok_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      load_ready_q   <= load_ready_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
      core_start_q   <= core_start_d;
      core_decrypt_q <= core_decrypt_d;
      auth_ok_q      <= auth_ok_d;
    end
  end

  // Input fields: a field only shifts while the beat index is inside its length.
  ascon_lane_sr #(.WIDTH(K), .STEP(W)) u_key (
    .clk(clk), .rst(rst), .en(load_acc), .load(1'b0), .load_val('0),
    .shl(cnt_q < CW'(K / W)), .lane_in(key_in), .shr(1'b0), .q(core_key));

  ascon_lane_sr #(.WIDTH(NB), .STEP(W)) u_nonce (
    .clk(clk), .rst(rst), .en(load_acc), .load(1'b0), .load_val('0),
    .shl(cnt_q < CW'(NB / W)), .lane_in(nonce_in), .shr(1'b0), .q(core_nonce));

  ascon_lane_sr #(.WIDTH(L), .STEP(W)) u_ad (
    .clk(clk), .rst(rst), .en(load_acc), .load(1'b0), .load_val('0),
    .shl(cnt_q < CW'(L / W)), .lane_in(ad_in), .shr(1'b0), .q(core_ad));

  ascon_lane_sr #(.WIDTH(Y), .STEP(W)) u_data (
    .clk(clk), .rst(rst), .en(load_acc), .load(1'b0), .load_val('0),
    .shl(cnt_q < CW'(Y / W)), .lane_in(data_in), .shr(1'b0), .q(core_data));

  ascon_lane_sr #(.WIDTH(T), .STEP(W)) u_texp (
    .clk(clk), .rst(rst), .en(load_acc), .load(1'b0), .load_val('0),
    .shl(cnt_q < CW'(T / W)), .lane_in(tag_in), .shr(1'b0), .q(texp));

  // Output shifters: loaded in CAPTURE, drained LSB chunk first.
  ascon_lane_sr #(.WIDTH(Y), .STEP(W), .OUT_W(W)) u_out_sr (
    .clk(clk), .rst(rst), .en(capture | unload_acc), .load(capture), .load_val(out_load),
    .shl(1'b0), .lane_in('0), .shr(1'b1), .q(data_out));

  ascon_lane_sr #(.WIDTH(T), .STEP(W), .OUT_W(W)) u_tag_sr (
    .clk(clk), .rst(rst), .en(capture | unload_acc), .load(capture), .load_val(core_tag),
    .shl(1'b0), .lane_in('0), .shr(1'b1), .q(tag_out));

  assign load_ready   = load_ready_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign core_start   = core_start_q;
  assign core_decrypt = core_decrypt_q;
  assign auth_ok      = auth_ok_q;

endmodule

// File: tb/tb_ascon_stream_if.sv
// Bench for ascon_stream_if at W=8: directed operations against a small
// behavioural model (expected beat streams, auth result, latency) plus a core stub.
module tb_ascon_stream_if;

  localparam int unsigned K   = 128;
  localparam int unsigned NB  = 128;
  localparam int unsigned L   = 32;
  localparam int unsigned Y   = 32;
  localparam int unsigned T   = 128;
  localparam int unsigned W   = 8;
  localparam int unsigned LB  = 16;  // 128 / 8
  localparam int unsigned UB  = 16;  // 128 / 8
  localparam int unsigned LAT = 20;  // core stub compute cycles

  logic          clk, rst;
  logic          load_valid, load_ready;
  logic [W-1:0]  key_in, nonce_in, ad_in, data_in, tag_in;
  logic          start, decrypt;
  logic          out_valid, out_ready;
  logic [W-1:0]  data_out, tag_out;
  logic          auth_ok, busy;
  logic [K-1:0]  core_key;
  logic [NB-1:0] core_nonce;
  logic [L-1:0]  core_ad;
  logic [Y-1:0]  core_data;
  logic          core_start, core_decrypt;
  logic [Y-1:0]  core_out;
  logic [T-1:0]  core_tag;
  logic          core_ready;

  ascon_stream_if #(.K(K), .NB(NB), .L(L), .Y(Y), .T(T), .W(W)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .key_in(key_in), .nonce_in(nonce_in), .ad_in(ad_in), .data_in(data_in), .tag_in(tag_in),
    .start(start), .decrypt(decrypt),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .tag_out(tag_out),
    .auth_ok(auth_ok), .busy(busy),
    .core_key(core_key), .core_nonce(core_nonce), .core_ad(core_ad), .core_data(core_data),
    .core_start(core_start), .core_decrypt(core_decrypt),
    .core_out(core_out), .core_tag(core_tag), .core_ready(core_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Core stub: ready rises LAT cycles after the start pulse, drops while start is seen.
  logic [Y-1:0] cout_v;
  logic [T-1:0] ctag_v;
  logic         rdy_q;
  int unsigned  tmr;
  int           cs_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b0;
      tmr   <= 0;
    end else if (core_start) begin
      rdy_q <= 1'b0;
      tmr   <= LAT;
    end else if (tmr != 0) begin
      tmr <= tmr - 1;
      if (tmr == 1) rdy_q <= 1'b1;
    end
    if (core_start) cs_cnt <= cs_cnt + 1;
  end

  assign core_ready = rdy_q && !core_start;
  assign core_out   = cout_v;
  assign core_tag   = ctag_v;

  // Model of the output stream for the current operation.
  logic           chk_en = 1'b0;
  logic [127:0]   exp_dat_v, exp_tag_v;
  logic           exp_auth;
  int             ck_idx = 0;

  always @(negedge clk) begin
    if (!chk_en) begin
      ck_idx = 0;
    end else if (!rst && out_valid) begin
      if (ck_idx >= int'(UB)) begin
        chk("beat_overrun", 128'(ck_idx), 128'(UB - 1));
      end else begin
        chk("data_out", 128'(data_out), 128'(exp_dat_v[ck_idx*W +: W]));
        chk("tag_out", 128'(tag_out), 128'(exp_tag_v[ck_idx*W +: W]));
        chk("auth_ok_hold", 128'(auth_ok), 128'(exp_auth));
      end
      if (out_ready) ck_idx = ck_idx + 1;
    end
  end

  // Operation descriptor.
  logic [K-1:0]  op_key;
  logic [NB-1:0] op_nonce;
  logic [L-1:0]  op_ad;
  logic [Y-1:0]  op_data;
  logic [T-1:0]  op_texp;
  logic          op_dec;
  bit            op_toggle, op_bp;
  int            op_start_beat;
  int            op_abort;  // 0 none, 1 in LOAD, 2 in RUN, 3 in UNLOAD
  logic [127:0]  col_dat, col_tag;

  task automatic do_reset();
    rst = 1'b1;
    load_valid = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b0;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_auth_ok", 128'(auth_ok), 128'(0));
    chk("rst_load_ready", 128'(load_ready), 128'(0));
    chk("rst_core_start", 128'(core_start), 128'(0));
    chk("rst_core_key", 128'(core_key), 128'(0));
    chk("rst_core_ad", 128'(core_ad), 128'(0));
    chk("rst_core_data", 128'(core_data), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_load_ready", 128'(load_ready), 128'(1));
  endtask

  task automatic run_op();
    int  b, g, cyc, beats, stall, cs0;
    bit  acc;
    col_dat = '0;
    col_tag = '0;
    cs0 = cs_cnt;
    b = 0;
    g = 0;
    while (b < int'(LB) && g < 400) begin
      load_valid = op_toggle ? (g % 2 == 0) : 1'b1;
      key_in   = op_key[K-1-b*W -: W];
      nonce_in = op_nonce[NB-1-b*W -: W];
      tag_in   = op_texp[T-1-b*W -: W];
      ad_in    = (b < int'(L / W)) ? op_ad[L-1-b*W -: W] : W'($urandom);
      data_in  = (b < int'(Y / W)) ? op_data[Y-1-b*W -: W] : W'($urandom);
      start    = (b == op_start_beat);
      acc = load_valid && load_ready;
      @(posedge clk); #1;
      g++;
      if (acc) b++;
      if (op_abort == 1 && b == 5) begin
        do_reset();
        return;
      end
    end
    load_valid = 1'b0;
    start = 1'b0;
    chk("load_beats", 128'(b), 128'(LB));
    chk("armed_load_ready", 128'(load_ready), 128'(0));
    chk("armed_busy", 128'(busy), 128'(1));
    chk("start_ignored", 128'(cs_cnt - cs0), 128'(0));
    chk("core_key", 128'(core_key), 128'(op_key));
    chk("core_nonce", 128'(core_nonce), 128'(op_nonce));
    chk("core_ad", 128'(core_ad), 128'(op_ad));
    chk("core_data", 128'(core_data), 128'(op_data));

    exp_auth  = !op_dec || (op_texp == ctag_v);
    exp_dat_v = exp_auth ? 128'(cout_v) : 128'(0);
    exp_tag_v = 128'(ctag_v);
    chk_en = 1'b1;

    start = 1'b1;
    decrypt = op_dec;
    @(posedge clk); #1;
    start = 1'b0;
    decrypt = ~op_dec;
    chk("core_start_rise", 128'(core_start), 128'(1));
    chk("core_decrypt", 128'(core_decrypt), 128'(op_dec));
    chk("auth_cleared", 128'(auth_ok), 128'(0));

    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk("core_start_width", 128'(core_start), 128'(0));
      if (op_abort == 2 && cyc == 5) begin
        do_reset();
        return;
      end
    end while (!out_valid && cyc < 200);
    chk("latency", 128'(cyc), 128'(LAT + 3));
    chk("auth_ok", 128'(auth_ok), 128'(exp_auth));

    beats = 0;
    g = 0;
    stall = 0;
    while (beats < int'(UB) && g < 400) begin
      if (op_bp && beats == 3 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      acc = out_valid && out_ready;
      if (acc) begin
        col_dat[beats*W +: W] = data_out;
        col_tag[beats*W +: W] = tag_out;
      end
      @(posedge clk); #1;
      g++;
      if (acc) beats++;
      if (op_abort == 3 && beats == 2) begin
        do_reset();
        return;
      end
    end
    out_ready = 1'b1;
    chk("unload_beats", 128'(beats), 128'(UB));
    chk("done_out_valid", 128'(out_valid), 128'(0));
    chk("done_busy", 128'(busy), 128'(0));
    chk("done_load_ready", 128'(load_ready), 128'(1));
    chk("done_auth_ok", 128'(auth_ok), 128'(exp_auth));
    chk("model_beats", 128'(ck_idx), 128'(UB));
    chk("core_start_count", 128'(cs_cnt - cs0), 128'(1));
    chk_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_op(input logic [K-1:0] key, input logic [NB-1:0] nonce,
                        input logic [L-1:0] ad, input logic [Y-1:0] data,
                        input logic [T-1:0] texp, input logic dec,
                        input logic [Y-1:0] cout, input logic [T-1:0] ctag,
                        input bit toggle, input bit bp, input int sbeat, input int abort);
    op_key = key; op_nonce = nonce; op_ad = ad; op_data = data; op_texp = texp;
    op_dec = dec; cout_v = cout; ctag_v = ctag;
    op_toggle = toggle; op_bp = bp; op_start_beat = sbeat; op_abort = abort;
  endtask

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] TAG_A = 128'h89abcdef01234567fedcba9876543210;
  localparam logic [127:0] TAG_C = 128'h55555555aaaaaaaa33333333cccccccc;

  initial begin
    rst = 1'b1;
    load_valid = 1'b0;
    key_in = '0; nonce_in = '0; ad_in = '0; data_in = '0; tag_in = '0;
    start = 1'b0; decrypt = 1'b0; out_ready = 1'b1;
    cout_v = '0; ctag_v = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_load_ready", 128'(load_ready), 128'(0));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_auth_ok", 128'(auth_ok), 128'(0));
    chk("reset_core_start", 128'(core_start), 128'(0));
    chk("reset_core_key", 128'(core_key), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_load_ready", 128'(load_ready), 128'(1));

    // Encrypt, with a stray start during load beat 10.
    set_op(KEY_A, 128'ha5a5a5a5_0f0f0f0f_12345678_9abcdef0, 32'h11223344, 32'hcafef00d,
           128'h0, 1'b0, 32'hdeadbeef, TAG_A, 1'b0, 1'b0, 10, 0);
    run_op();
    chk("enc_core_key_lit", 128'(core_key), 128'h000102030405060708090a0b0c0d0e0f);
    chk("enc_data_lit", col_dat, {96'h0, 32'hdeadbeef});
    chk("enc_tag_lit", col_tag, TAG_A);

    // Decrypt with matching tag and mid-unload backpressure.
    set_op(128'hfedcba98_76543210_00112233_44556677, 128'h1, 32'h0badf00d, 32'h01020304,
           TAG_C, 1'b1, 32'h12345678, TAG_C, 1'b0, 1'b1, -1, 0);
    run_op();
    chk("dec_ok_data_lit", col_dat, {96'h0, 32'h12345678});

    // Decrypt with one flipped tag bit and toggling load_valid.
    set_op(128'h0123, 128'h4567, 32'h89abcdef, 32'h76543210,
           TAG_C ^ 128'h1, 1'b1, 32'ha5a55a5a, TAG_C, 1'b1, 1'b0, -1, 0);
    run_op();
    chk("dec_bad_data_lit", col_dat, 128'h0);
    chk("dec_bad_tag_lit", col_tag, TAG_C);
    chk("dec_bad_auth_lit", 128'(auth_ok), 128'(0));

    // Resets in LOAD, RUN and UNLOAD.
    set_op(KEY_A, 128'h2, 32'h3, 32'h4, 128'h5, 1'b0, 32'h6, TAG_A, 1'b0, 1'b0, -1, 1);
    run_op();
    set_op(KEY_A, 128'h2, 32'h3, 32'h4, 128'h5, 1'b0, 32'h6, TAG_A, 1'b0, 1'b0, -1, 2);
    run_op();
    set_op(KEY_A, 128'h2, 32'h3, 32'h4, 128'h5, 1'b0, 32'h6, TAG_A, 1'b0, 1'b0, -1, 3);
    run_op();

    // Full encrypt after the resets.
    set_op(KEY_A, 128'h77, 32'h11223344, 32'hcafef00d, 128'h0, 1'b0, 32'hdeadbeef, TAG_A,
           1'b0, 1'b0, -1, 0);
    run_op();
    chk("post_rst_data_lit", col_dat, {96'h0, 32'hdeadbeef});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
